// File: rtl/diff_frame_ctrl.sv
// Frame sequencer for the diff datapath: RAM read issue, beat framing, drain/done.
// Optional DIFF_FRAME_CTRL_PERF_EN adds a saturating frame-cycle counter output.
module diff_frame_ctrl #(
   parameter int READ_RAM_WIDTH = 128,
   parameter int SAMPLE_WIDTH   = 32,
   parameter int NUM            = 8,
   parameter int ADDR_W         = 10,
   parameter int LEN_W          = 10,
   parameter int RAM_LAT        = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_start,
   input  logic [ADDR_W-1:0]         i_base_addr,
   input  logic [LEN_W-1:0]          i_len,
   input  logic                      i_mode,
   input  logic                      i_hold,
   output logic                      o_busy,
   output logic                      o_ram_rd_en,
   output logic [ADDR_W-1:0]         o_ram_addr,
   input  logic [READ_RAM_WIDTH-1:0] i_ram_rd_data,
   output logic [READ_RAM_WIDTH-1:0] o_x0_data,
   output logic                      o_x0_valid,
   output logic                      o_x0_last,
   output logic                      o_switch,
   input  logic                      i_y0_valid,
   output logic                      o_done,
   output logic                      o_err
`ifdef DIFF_FRAME_CTRL_PERF_EN
   ,
   output logic [15:0]               o_frame_cycles
`endif
);

   localparam int LANE_W = SAMPLE_WIDTH / 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    iss_cnt;
   logic [LEN_W-1:0]    y_cnt;
   logic [LEN_W-1:0]    y_cnt_nx;
   logic                switch_q;
   logic                err_q;
   logic                done_q;
   logic                accept;
   logic                reject;
   logic                last_rd;
   logic                y_inc;
   logic                done_nx;
   logic [RAM_LAT-1:0]  vld_sr;
   logic [RAM_LAT-1:0]  lst_sr;

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      reject   = 1'b0;
      last_rd  = 1'b0;
      done_nx  = 1'b0;
      // Pulses beyond the frame length are dropped, never counted.
      y_inc    = i_y0_valid && (state != IDLE) && (y_cnt != len_q);
      y_cnt_nx = y_cnt + LEN_W'(y_inc);
      unique case (state)
         IDLE: begin
            if (i_start && !i_hold) begin
               if (i_len != '0) begin
                  accept   = 1'b1;
                  state_nx = ISSUE;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         ISSUE: begin
            reject  = i_start;
            last_rd = (iss_cnt == len_q - LEN_W'(1));
            if (last_rd) state_nx = DRAIN;
         end
         DRAIN: begin
            reject = i_start;
            if (y_cnt_nx == len_q) begin
               done_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         iss_cnt  <= '0;
         y_cnt    <= '0;
         switch_q <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         vld_sr   <= '0;
         lst_sr   <= '0;
      end else begin
         state  <= state_nx;
         err_q  <= reject;
         done_q <= done_nx;
         if (accept) begin
            addr_q   <= i_base_addr;
            len_q    <= i_len;
            switch_q <= i_mode;
            iss_cnt  <= '0;
            y_cnt    <= '0;
         end else begin
            if (state == ISSUE) begin
               addr_q  <= addr_q + ADDR_W'(1);
               iss_cnt <= iss_cnt + LEN_W'(1);
            end
            y_cnt <= y_cnt_nx;
         end
         vld_sr[0] <= (state == ISSUE);
         lst_sr[0] <= last_rd;
         for (int i = 1; i < RAM_LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            lst_sr[i] <= lst_sr[i-1];
         end
      end
   end

`ifdef DIFF_FRAME_CTRL_PERF_EN
   logic [15:0] cyc_q;

   // Starts at 2 so the accept cycle and the done cycle are both included.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q          <= '0;
         o_frame_cycles <= '0;
      end else begin
         if (accept) begin
            cyc_q <= 16'd2;
         end else if (state != IDLE && cyc_q != 16'hFFFF) begin
            cyc_q <= cyc_q + 16'd1;
         end
         if (done_nx) begin
            o_frame_cycles <= (cyc_q == 16'hFFFF) ? 16'hFFFF
                                                  : cyc_q + 16'd1;
         end
      end
   end
`endif

   assign o_busy      = (state != IDLE);
   assign o_ram_rd_en = (state == ISSUE);
   assign o_ram_addr  = addr_q;
   assign o_x0_valid  = vld_sr[RAM_LAT-1];
   assign o_x0_last   = lst_sr[RAM_LAT-1];
   assign o_switch    = switch_q;
   assign o_done      = done_q;
   assign o_err       = err_q;

   // Lanes pass straight through; gated so the bus is quiet between beats.
   always_comb begin
      o_x0_data = '0;
      for (int k = 0; k < NUM; k++) begin
         o_x0_data[k*LANE_W +: LANE_W] =
            i_ram_rd_data[k*LANE_W +: LANE_W] & {LANE_W{o_x0_valid}};
      end
   end

endmodule

// File: tb/tb_diff_frame_ctrl.sv
// Randomized bench for diff_frame_ctrl with RAM and diff-pipeline emulation.
// Expected timing is derived per frame from base, len, mode and RAM latency.
module tb_diff_frame_ctrl;

   localparam int LAT = 1;
   localparam int DW  = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [9:0]    i_base_addr;
   logic [9:0]    i_len;
   logic          i_mode;
   logic          i_hold;
   logic          o_busy;
   logic          o_ram_rd_en;
   logic [9:0]    o_ram_addr;
   logic [DW-1:0] i_ram_rd_data;
   logic [DW-1:0] o_x0_data;
   logic          o_x0_valid;
   logic          o_x0_last;
   logic          o_switch;
   logic          i_y0_valid;
   logic          o_done;
   logic          o_err;
`ifdef DIFF_FRAME_CTRL_PERF_EN
   logic [15:0]   o_frame_cycles;
`endif

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem [1024];
   logic [DW-1:0] rpipe [LAT];
   logic [3:0]    ypipe;

   always #5 clk = ~clk;

   diff_frame_ctrl #(.RAM_LAT(LAT)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_base_addr   (i_base_addr),
      .i_len         (i_len),
      .i_mode        (i_mode),
      .i_hold        (i_hold),
      .o_busy        (o_busy),
      .o_ram_rd_en   (o_ram_rd_en),
      .o_ram_addr    (o_ram_addr),
      .i_ram_rd_data (i_ram_rd_data),
      .o_x0_data     (o_x0_data),
      .o_x0_valid    (o_x0_valid),
      .o_x0_last     (o_x0_last),
      .o_switch      (o_switch),
      .i_y0_valid    (i_y0_valid),
      .o_done        (o_done),
      .o_err         (o_err)
`ifdef DIFF_FRAME_CTRL_PERF_EN
      ,
      .o_frame_cycles(o_frame_cycles)
`endif
   );

   // RAM with LAT-cycle read; idle cycles return junk to expose ungated data.
   always @(posedge clk) begin
      rpipe[0] <= o_ram_rd_en ? mem[o_ram_addr] : {4{$urandom}};
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign i_ram_rd_data = rpipe[LAT-1];

   // Stand-in for the 4-stage diff pipeline.
   always @(posedge clk) begin
      if (rst) ypipe <= '0;
      else     ypipe <= {ypipe[2:0], o_x0_valid};
   end
   assign i_y0_valid = ypipe[3];

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic [9:0] base, input logic [9:0] len,
                            input logic mode, input bit inject);
      int done_k;
      logic [9:0] a;
      done_k      = LAT + int'(len) + 4;
      i_start     = 1'b1;
      i_base_addr = base;
      i_len       = len;
      i_mode      = mode;
      i_hold      = 1'b0;
      tick();
      i_start = 1'b0;
      for (int k = 0; k <= done_k; k++) begin
         bit in_rd;
         bit in_x;
         in_rd = (k < int'(len));
         in_x  = (k >= LAT) && (k < LAT + int'(len));
         chk("rd_en", o_ram_rd_en, in_rd);
         if (in_rd) begin
            a = base + 10'(k);
            chk("addr", o_ram_addr, a);
         end
         chk("x0_valid", o_x0_valid, in_x);
         chk("x0_last", o_x0_last, k == LAT + int'(len) - 1);
         if (in_x) begin
            a = base + 10'(k - LAT);
            chk("x0_data", o_x0_data, mem[a]);
         end else begin
            chk("x0_idle", o_x0_data, '0);
         end
         chk("switch", o_switch, mode);
         chk("busy", o_busy, k < done_k);
         chk("done", o_done, k == done_k);
         chk("err", o_err, inject && k == 2);
`ifdef DIFF_FRAME_CTRL_PERF_EN
         if (k == done_k) chk("cycles", o_frame_cycles, 16'(done_k + 2));
`endif
         i_start = inject && (k == 1);
         i_len   = 10'($urandom_range(0, 1023));
         i_hold  = (k < done_k) ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
      end
      i_start = 1'b0;
      i_hold  = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++)
         mem[i] = {$urandom, $urandom, $urandom, $urandom};
      rst         = 1'b1;
      i_start     = 1'b0;
      i_base_addr = '0;
      i_len       = '0;
      i_mode      = 1'b0;
      i_hold      = 1'b0;
      repeat (3) tick();
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_rd", o_ram_rd_en, 1'b0);
      chk("rst_addr", o_ram_addr, '0);
      chk("rst_sw", o_switch, 1'b0);
      chk("rst_done", o_done, 1'b0);
      rst = 1'b0;
      tick();

      run_frame(10'h010, 10'd4, 1'b1, 1'b0);
      run_frame(10'h3FE, 10'd3, 1'b0, 1'b0);
      run_frame(10'h155, 10'd1, 1'b1, 1'b0);

      i_start = 1'b1;
      i_len   = '0;
      tick();
      i_start = 1'b0;
      chk("len0_err", o_err, 1'b1);
      chk("len0_rd", o_ram_rd_en, 1'b0);
      chk("len0_busy", o_busy, 1'b0);
      tick();
      chk("len0_err_end", o_err, 1'b0);

      i_start = 1'b1;
      i_hold  = 1'b1;
      i_len   = 10'd5;
      tick();
      i_start = 1'b0;
      i_hold  = 1'b0;
      chk("hold_busy", o_busy, 1'b0);
      chk("hold_err", o_err, 1'b0);
      chk("hold_rd", o_ram_rd_en, 1'b0);

      run_frame(10'h200, 10'd6, 1'b0, 1'b1);

      i_start     = 1'b1;
      i_base_addr = 10'h0A0;
      i_len       = 10'd8;
      i_mode      = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_busy", o_busy, 1'b0);
      chk("mr_rd", o_ram_rd_en, 1'b0);
      chk("mr_addr", o_ram_addr, '0);
      chk("mr_valid", o_x0_valid, 1'b0);
      chk("mr_last", o_x0_last, 1'b0);
      chk("mr_data", o_x0_data, '0);
      chk("mr_sw", o_switch, 1'b0);
      chk("mr_done", o_done, 1'b0);
      chk("mr_err", o_err, 1'b0);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("mr_nodone", o_done, 1'b0);
         chk("mr_idle", o_busy, 1'b0);
      end
      run_frame(10'h0A0, 10'd2, 1'b1, 1'b0);

      run_frame(10'h300, 10'd2, 1'b1, 1'b0);
      run_frame(10'h301, 10'd5, 1'b0, 1'b0);

      for (int n = 0; n < 10; n++) begin
         run_frame(10'($urandom_range(0, 1023)),
                   10'($urandom_range(1, 20)),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
